// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e    : MMIO handshake FSM states
//   dout_src_e : which register currently drives mem_dout
//   rot_left8  : byte-granular left rotation used to place store data on lanes
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SRC_ZERO,  // nothing loaded since reset
    SRC_RAM,   // registered RAM read port
    SRC_MMIO   // word captured from the peripheral (or the error word)
  } dout_src_e;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hAAAAA000;
  localparam logic [31:0] ERR_DATA_DEFAULT  = 32'hDEADBEEF;

  // Rotate a word left by 8*sel bits so lane-0 data lands on lane sel.
  function automatic logic [31:0] rot_left8(input logic [31:0] word,
                                            input logic [1:0]  sel);
    logic [31:0] r;
    case (sel)
      2'd0:    r = word;
      2'd1:    r = {word[23:0], word[31:24]};
      2'd2:    r = {word[15:0], word[31:16]};
      default: r = {word[7:0],  word[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_bram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port that holds its value when re_i is low.
//   clk     : clock
//   we_i    : byte-lane write enables
//   re_i    : read enable (loads rdata_o at the edge)
//   addr_i  : word index
//   wdata_i : write data, already lane-aligned
//   rdata_o : registered read word
module dmem_bram #(
  parameter  int DEPTH_WORDS = 4096,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: no reset on the array or its read register; a reset here would
  // stop the tools mapping it onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder. Ordinary loads/stores go to an internal
// byte-enabled RAM; accesses inside the 4 KiB MMIO window are forwarded to a
// peripheral over req/ack while the pipeline is stalled.
//   clk, Rst        : clock, asynchronous active-low reset
//   mem_wea/mem_rea : store / load request (store wins if both)
//   mem_en          : byte-lane write enables, already rotated
//   mem_addr        : byte address
//   mem_din         : store data, lane-0 aligned
//   mem_dout        : registered raw read word
//   mem_hold        : pipeline stall (combinational)
//   mmio_*          : peripheral request, write flag, offset, enables,
//                     rotated write data, read data, ack pulse
//   mmio_err        : sticky timeout flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
  parameter logic [7:0]  TIMEOUT     = 8'd255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [11:0] mmio_addr,
  output logic [3:0]  mmio_be,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ack,
  output logic        mmio_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q;
  dout_src_e   src_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] mmio_word_q;

  logic             req;
  logic             mmio_hit;
  logic             ram_access;
  logic [3:0]       ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      wdata_rot;
  logic [31:0]      ram_rdata;

  assign req       = mem_wea | mem_rea;
  assign mmio_hit  = req && (mem_addr[31:12] == MMIO_BASE[31:12]);
  assign ram_idx   = mem_addr[IDX_W+1:2];
  assign wdata_rot = rot_left8(mem_din, mem_addr[1:0]);

  // The RAM is touched only from IDLE: in WAIT/DONE the inputs still show the
  // held MMIO request, and mem_dout must not be reloaded at the DONE edge.
  assign ram_access = (state_q == IDLE) && req && !mmio_hit;
  assign ram_we     = {4{ram_access && mem_wea}} & mem_en;
  assign ram_re     = ram_access && !mem_wea && mem_rea;

  assign mem_hold = ((state_q == IDLE) && mmio_hit) || (state_q == WAIT);

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_idx),
    .wdata_i(wdata_rot),
    .rdata_o(ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_ZERO;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 12'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mmio_word_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mmio_hit) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            we_q    <= mem_wea;
            addr_q  <= mem_addr[11:0];
            be_q    <= mem_en;
            wdata_q <= wdata_rot;
            cnt_q   <= 8'd0;
          end else if (ram_re) begin
            src_q <= SRC_RAM;
          end
        end
        WAIT: begin
          // cnt_q counts completed WAIT cycles, so the compare against
          // TIMEOUT-1 fires in the TIMEOUT-th WAIT cycle.
          if (mmio_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              mmio_word_q <= mmio_rdata;
              src_q       <= SRC_MMIO;
            end
          end else if (cnt_q == TIMEOUT - 8'd1) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            if (!we_q) begin
              mmio_word_q <= ERR_DATA;
              src_q       <= SRC_MMIO;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: default assignment first so the combinational mux cannot infer a latch.
  always_comb begin
    mem_dout = 32'd0;
    case (src_q)
      SRC_RAM:  mem_dout = ram_rdata;
      SRC_MMIO: mem_dout = mmio_word_q;
      default:  mem_dout = 32'd0;
    endcase
  end

  assign mmio_req   = req_q;
  assign mmio_we    = we_q;
  assign mmio_addr  = addr_q;
  assign mmio_be    = be_q;
  assign mmio_wdata = wdata_q;
  assign mmio_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [7:0]  TMO   = 8'd4;
  localparam logic [31:0] ERRW  = 32'hDEADBEEF;

  logic        clk;
  logic        Rst;
  logic        mem_wea, mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_hold;
  logic        mmio_req, mmio_we;
  logic [11:0] mmio_addr;
  logic [3:0]  mmio_be;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic        mmio_ack, mmio_err;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE  (32'hAAAAA000),
    .TIMEOUT    (TMO),
    .ERR_DATA   (ERRW)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .mem_wea   (mem_wea),
    .mem_rea   (mem_rea),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_hold  (mem_hold),
    .mmio_req  (mmio_req),
    .mmio_we   (mmio_we),
    .mmio_addr (mmio_addr),
    .mmio_be   (mmio_be),
    .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata),
    .mmio_ack  (mmio_ack),
    .mmio_err  (mmio_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word-addressed memory plus the expected visible outputs.
  logic [31:0] model_mem [int];
  logic [31:0] cur_dout;
  logic        err_state;
  logic        exp_hold, exp_req;
  logic [31:0] exp_dout;
  logic        exp_we;
  logic [11:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  bit          cmp_en;
  int          hold_cnt = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] t;
    t = {d, d} << (8 * off);
    return t[63:32];
  endfunction

  always @(negedge clk) begin
    if (mem_hold) hold_cnt++;
    if (cmp_en) begin
      check("mem_hold", mem_hold, exp_hold);
      check("mem_dout", mem_dout, exp_dout);
      check("mmio_req", mmio_req, exp_req);
      check("mmio_err", mmio_err, err_state);
      if (exp_req) begin
        check("mmio_we", mmio_we, exp_we);
        check("mmio_addr", mmio_addr, exp_addr);
        check("mmio_be", mmio_be, exp_be);
        check("mmio_wdata", mmio_wdata, exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One non-MMIO cycle (RAM access or idle).
  task automatic ram_op(input logic wea, input logic rea, input logic [3:0] en,
                        input logic [31:0] addr, input logic [31:0] din);
    logic [31:0] w, d;
    int i;
    mem_wea = wea; mem_rea = rea; mem_en = en; mem_addr = addr; mem_din = din;
    exp_hold = 1'b0; exp_req = 1'b0; exp_dout = cur_dout;
    i = widx(addr);
    if (wea) begin
      w = model_mem.exists(i) ? model_mem[i] : 32'h0;
      d = rot(din, addr[1:0]);
      for (int b = 0; b < 4; b++) if (en[b]) w[8*b +: 8] = d[8*b +: 8];
      model_mem[i] = w;
    end else if (rea) begin
      cur_dout = model_mem[i];
    end
    step();
  endtask

  task automatic idle();
    ram_op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Full MMIO transaction: decode cycle, WAIT cycles, DONE cycle.
  // ack_at = WAIT cycle (1-based) carrying the ack; 0 = never (timeout).
  task automatic mmio_op(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic [3:0] en, input int ack_at, input logic [31:0] rdata,
                         input logic done_ack, input bit lit_en, input logic [11:0] lit_addr);
    int   nwait;
    logic tmo;
    mem_wea = we; mem_rea = !we; mem_en = en; mem_addr = addr; mem_din = din;
    mmio_ack = 1'b0;
    exp_hold = 1'b1; exp_req = 1'b0; exp_dout = cur_dout;
    step();
    tmo   = !(ack_at >= 1 && ack_at <= int'(TMO));
    nwait = tmo ? int'(TMO) : ack_at;
    exp_we = we; exp_addr = addr[11:0]; exp_be = en; exp_wdata = rot(din, addr[1:0]);
    for (int w = 1; w <= nwait; w++) begin
      mmio_ack = (w == ack_at); mmio_rdata = rdata;
      exp_hold = 1'b1; exp_req = 1'b1;
      if (lit_en && w == 1) begin
        #1;
        check("lit_mmio_addr", mmio_addr, lit_addr);
        check("lit_mmio_we", mmio_we, we);
      end
      step();
    end
    if (!we) cur_dout = tmo ? ERRW : rdata;
    if (tmo) err_state = 1'b1;
    // DONE: inputs still held; an ack here must be ignored.
    mmio_ack = done_ack; mmio_rdata = ~rdata;
    exp_hold = 1'b0; exp_req = 1'b0; exp_dout = cur_dout;
    step();
    mmio_ack = 1'b0; mem_wea = 1'b0; mem_rea = 1'b0;
  endtask

  int hs;

  initial begin
    cmp_en = 0; Rst = 1'b0;
    mem_wea = 0; mem_rea = 0; mem_en = 0; mem_addr = 0; mem_din = 0;
    mmio_rdata = 0; mmio_ack = 0;
    cur_dout = 0; err_state = 0;
    exp_hold = 0; exp_req = 0; exp_dout = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;

    #3;
    check("rst_dout", mem_dout, 32'h0);
    check("rst_req", mmio_req, 1'b0);
    check("rst_err", mmio_err, 1'b0);
    check("rst_hold", mem_hold, 1'b0);
    check("rst_mmio_addr", mmio_addr, 12'h0);
    check("rst_mmio_wdata", mmio_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b1; cmp_en = 1;

    // Word store / load
    ram_op(1, 0, 4'hF, 32'h100, 32'h11223344);
    ram_op(0, 1, 4'hF, 32'h100, 32'h0);
    check("lit_lw_100", mem_dout, 32'h11223344);

    // Byte and wrapping halfword lanes
    ram_op(1, 0, 4'hF, 32'h100, 32'h0);
    ram_op(1, 0, 4'b0010, 32'h101, 32'h000000AB);
    ram_op(0, 1, 4'hF, 32'h100, 32'h0);
    check("lit_sb_101", mem_dout, 32'h0000AB00);
    ram_op(1, 0, 4'b1001, 32'h103, 32'h0000CDEF);
    ram_op(0, 1, 4'h0, 32'h100, 32'h0);
    check("lit_sh_103", mem_dout, 32'hEF00ABCD);

    // Aliasing, store priority, just-outside-window address, idle hold
    ram_op(1, 0, 4'hF, 32'h504, 32'hA5A55A5A);
    ram_op(0, 1, 4'hF, 32'h104, 32'h0);
    check("lit_alias", mem_dout, 32'hA5A55A5A);
    ram_op(1, 1, 4'hF, 32'h108, 32'h600DCAFE);
    ram_op(0, 1, 4'h0, 32'h108, 32'h0);
    ram_op(1, 0, 4'hF, 32'hAAAAB000, 32'h13579BDF);
    ram_op(0, 1, 4'hF, 32'h0, 32'h0);
    idle();
    idle();
    check("lit_hold_value", mem_dout, 32'h13579BDF);

    // MMIO write, ack on 3rd WAIT cycle: 4 stall cycles
    hs = hold_cnt;
    mmio_op(1, 32'hAAAAA004, 32'h55, 4'hF, 3, 32'h0, 1'b0, 1, 12'h004);
    check("lit_hold_cycles_wr", 32'(hold_cnt - hs), 32'd4);
    // Back-to-back MMIO byte write, minimum latency: 2 stall cycles
    hs = hold_cnt;
    mmio_op(1, 32'hAAAAA00E, 32'h77, 4'b0100, 1, 32'h0, 1'b0, 1, 12'h00E);
    check("lit_hold_cycles_min", 32'(hold_cnt - hs), 32'd2);

    // MMIO read; ack during DONE ignored; following RAM read must not clobber early
    mmio_op(0, 32'hAAAAA008, 32'h0, 4'hF, 2, 32'hCAFEF00D, 1'b1, 0, 12'h0);
    check("lit_mmio_rd", mem_dout, 32'hCAFEF00D);
    ram_op(0, 1, 4'hF, 32'h100, 32'h0);
    check("lit_ram_after_mmio", mem_dout, 32'hEF00ABCD);

    // Timeout: TMO WAIT cycles, error word, sticky flag
    hs = hold_cnt;
    mmio_op(0, 32'hAAAAA020, 32'h0, 4'hF, 0, 32'h0, 1'b0, 0, 12'h0);
    check("lit_hold_cycles_tmo", 32'(hold_cnt - hs), 32'd5);
    check("lit_tmo_dout", mem_dout, 32'hDEADBEEF);
    check("lit_tmo_err", mmio_err, 1'b1);
    ram_op(0, 1, 4'hF, 32'h104, 32'h0);
    idle();
    check("lit_err_sticky", mmio_err, 1'b1);

    // Reset in the middle of WAIT
    mem_wea = 0; mem_rea = 1; mem_en = 4'hF; mem_addr = 32'hAAAAA010; mem_din = 0;
    exp_hold = 1; exp_req = 0; exp_dout = cur_dout;
    step();
    exp_we = 0; exp_addr = 12'h010; exp_be = 4'hF; exp_wdata = 32'h0; exp_req = 1;
    step();
    cmp_en = 0;
    Rst = 1'b0; mem_rea = 1'b0;
    #1;
    check("midrst_req", mmio_req, 1'b0);
    check("midrst_dout", mem_dout, 32'h0);
    check("midrst_hold", mem_hold, 1'b0);
    check("midrst_err", mmio_err, 1'b0);
    cur_dout = 0; err_state = 0;
    @(posedge clk);
    #1;
    Rst = 1'b1; cmp_en = 1;
    mmio_ack = 1'b1; mmio_rdata = 32'h01234567;
    idle();
    mmio_ack = 1'b0;
    idle();
    check("lit_late_ack_dout", mem_dout, 32'h0);
    check("lit_late_ack_req", mmio_req, 1'b0);

    // Recovery after reset
    mmio_op(0, 32'hAAAAA00C, 32'h0, 4'hF, 1, 32'h0BADF00D, 1'b0, 1, 12'h00C);
    check("lit_recover", mem_dout, 32'h0BADF00D);
    idle();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that terminates the pipeline's MEM-stage memory request interface (mem_wea/mem_rea/mem_en/mem_addr/mem_din → mem_dout/mem_hold). It services ordinary loads and stores from an internal byte-enabled synchronous RAM. Accesses that fall in the MMIO window are forwarded to a peripheral over a req/ack handshake, and the pipeline is stalled with mem_hold until the access completes or times out. Returned words are raw and unrotated; the MEM stage performs load alignment and extension.

## Interface
- DEPTH_WORDS, 4096: RAM size in 32-bit words; power of two.
- MMIO_BASE, 32'hAAAAA000: MMIO window base address; the window is 4 KiB, matched on addr[31:12].
- TIMEOUT, 255: maximum cycles to wait for mmio_ack before forced completion; 8-bit counter.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out MMIO access.

Ports:
- clk  in  1  system clock, rising edge
- Rst  in  1  reset; asynchronous and active-low
- mem_wea  in  1  store request
- mem_rea  in  1  load request
- mem_en  in  4  byte-lane enables, already rotated by addr[1:0]; qualifies writes only
- mem_addr  in  32  byte address
- mem_din  in  32  store data, lane-0 aligned (not rotated)
- mem_dout  out  32  registered read word
- mem_hold  out  1  pipeline stall
- mmio_req  out  1  peripheral request
- mmio_we  out  1  peripheral write
- mmio_addr  out  12  window offset
- mmio_be  out  4  peripheral byte enables
- mmio_wdata  out  32  rotated store data
- mmio_rdata  in  32  peripheral read data
- mmio_ack  in  1  one-cycle completion pulse
- mmio_err  out  1  sticky timeout flag

## Operation
- **Request definition:** a request is present when mem_wea or mem_rea is high. mem_wea has priority if both are high.
- **Address decode:** mmio_hit = request && mem_addr[31:12] == MMIO_BASE[31:12]. Any other request is a RAM access.
- **RAM indexing:** index = mem_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits alias.
- **Store data alignment:** wdata = mem_din rotated left by 8*mem_addr[1:0]. For an sh at offset 3, lanes 3 and 0 both land in the same word.
- **RAM store:** writes the lanes where mem_en[i] && mem_wea.
- **RAM load:** reads the whole word; mem_en is ignored.
- **FSM states:**
  - IDLE: when mmio_hit, assert mmio_req and drive mmio_we/addr/be/wdata from the current request, then go to WAIT.
  - WAIT: when mmio_ack, capture mmio_rdata into mem_dout (loads only) and go to DONE. When the counter reaches TIMEOUT, capture ERR_DATA into mem_dout (loads only), set mmio_err, and go to DONE.
  - DONE: one cycle with mem_hold=0 so the pipeline advances. mem_dout is not reloaded at the DONE edge. Return to IDLE.
- **mem_hold** = (IDLE && mmio_hit) || WAIT. It is combinational, so the stall takes effect in the first cycle of the hit.
- **Request stability:** the requester holds request fields stable while mem_hold=1. The responder registers the MMIO fields at entry to WAIT and ignores input changes afterwards.
- **mmio_req:** high for the full WAIT state; deasserted in the cycle after ack.
- **mmio_err:** cleared only by reset.

## Timing
- **Reset values (asynchronous, Rst=0):** mem_dout=0, state=IDLE, mmio_req=0, mmio_we=0, mmio_addr=0, mmio_be=0, mmio_wdata=0, mmio_err=0, counter=0. RAM contents are not reset.
- **mem_hold during reset:** it is combinational from IDLE, so it is 0 unless mmio_hit is present.
- **RAM load:** address sampled at edge N; word valid on mem_dout after edge N, i.e. in the cycle the MEM_WB registers hold that instruction.
- **RAM store:** committed at edge N. A load of the same word issued at N+1 returns the new data; there is no same-cycle read-during-write requirement.
- **mem_dout when idle:** holds its value in cycles with no request and while in WAIT.
- **MMIO minimum latency:** hit at cycle C, mmio_req from C+1, ack at C+1, DONE at C+2, pipeline advances at the end of C+2. The stall is 2 cycles.
- **MMIO timeout:** forced completion after TIMEOUT WAIT cycles without ack.
- **Ack ordering:** an ack arriving in IDLE or DONE is ignored.
- **Reset mid-MMIO:** abandons the transaction: mmio_req drops immediately and the FSM returns to IDLE. The peripheral tolerates abandoned requests.
- **Back-to-back MMIO requests:** the second is decoded in the cycle after DONE.

## Structure
- **Package dmem_pkg:**
  - state enum {IDLE, WAIT, DONE}
  - MMIO_BASE default
  - ERR_DATA
  - function rot_left8(word, sel) for store alignment
- **Sub-module dmem_bram:** single-port synchronous RAM with a 4-bit byte write enable and registered read. It is instantiated once and infers BRAM.
- **Top level:** decode, store-data rotation, FSM, timeout counter, and the mem_dout mux (RAM output versus captured MMIO word).

## Test plan
- **Store word / load word:** sw 32'h11223344 to 0x100, then lw 0x100 → mem_dout=32'h11223344 one cycle after the load address; mem_hold stays 0 throughout.
- **Byte and wrapping-halfword lanes:** sb din=32'h000000AB at 0x101 with en=0010 over word 0 → word reads 32'h0000AB00. sh din=32'h0000CDEF at 0x103 with en=1001 → lane 3=EF, lane 0=CD.
- **MMIO write:** sw 32'h55 to 0xAAAAA004, ack on the 3rd WAIT cycle → mmio_addr=12'h004, mmio_we=1, mem_hold high for 4 cycles, then exactly one DONE cycle.
- **MMIO read:** lw 0xAAAAA008, mmio_rdata=32'hCAFEF00D with ack → mem_dout=32'hCAFEF00D in the cycle after DONE; a simultaneous RAM read does not overwrite it.
- **MMIO timeout:** lw MMIO with no ack, TIMEOUT=4 → DONE after 4 WAIT cycles, mem_dout=32'hDEADBEEF, mmio_err=1 until reset.
- **Reset mid-WAIT:** assert Rst=0 during WAIT → mmio_req=0, state=IDLE, mem_dout=0 asynchronously; a late ack after release has no effect.
